wb_arbiter: RTL and testbench

- Writeback initiator that drives the write port (rd, wen, dataD) of the LemonPC register file.
- Accepts results from two producers, ALU and LSU, over valid/ready handshakes.
- Buffers one result per producer and arbitrates between them, so the register file receives at most one write per cycle.
- Exports a per-register pending mask that the decode/hazard logic uses for RAW stalls.

---
 rtl/wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback initiator for the LemonPC register file write port.
//
// Takes results from the ALU and the LSU over valid/ready handshakes, holds
// one result per producer, and grants at most one of them per cycle onto the
// registered write port (wen, rd, dataD). The LSU wins ties, but the ALU is
// guaranteed a grant after STARVE_MAX consecutive LSU grants while it waits.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   alu_valid/alu_ready           ALU handshake; alu_rd, alu_data payload
//   lsu_valid/lsu_ready           LSU handshake; lsu_rd, lsu_data payload
//   wen, rd, dataD                registered register-file write port
//   pending                       per-register "write in flight" mask (bit 0 = 0)
//
// Optional build macro: WB_TRACE_EN -- prints each port write and each
// dropped x0 write in simulation. Synthesised logic is the same either way.
//
// Buffer state (one per source):
//   state | meaning
//   EMPTY | no result held, ready to accept
//   FULL  | one result held, waiting for a grant

module wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int STARVE_MAX = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_WIDTH-1:0]      alu_rd,
    input  logic [DATA_WIDTH-1:0]      alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [ADDR_WIDTH-1:0]      lsu_rd,
    input  logic [DATA_WIDTH-1:0]      lsu_data,
    output logic                       wen,
    output logic [ADDR_WIDTH-1:0]      rd,
    output logic [DATA_WIDTH-1:0]      dataD,
    output logic [(1<<ADDR_WIDTH)-1:0] pending
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

    buf_state_t alu_state, alu_state_nxt;
    buf_state_t lsu_state, lsu_state_nxt;

    logic [ADDR_WIDTH-1:0] alu_buf_rd, lsu_buf_rd;
    logic [DATA_WIDTH-1:0] alu_buf_data, lsu_buf_data;
    logic [CW-1:0]         starve_cnt, starve_cnt_nxt;

    logic                  alu_full, lsu_full, starved;
    logic                  gnt_alu, gnt_lsu, grant;
    logic                  alu_load, lsu_load;
    logic [ADDR_WIDTH-1:0] gnt_rd;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  wen_nxt;

    // State registers and buffer payloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_state    <= EMPTY;
            lsu_state    <= EMPTY;
            alu_buf_rd   <= '0;
            alu_buf_data <= '0;
            lsu_buf_rd   <= '0;
            lsu_buf_data <= '0;
            starve_cnt   <= '0;
            wen          <= 1'b0;
            rd           <= '0;
            dataD        <= '0;
        end else begin
            alu_state  <= alu_state_nxt;
            lsu_state  <= lsu_state_nxt;
            starve_cnt <= starve_cnt_nxt;
            wen        <= wen_nxt;
            if (alu_load) begin
                alu_buf_rd   <= alu_rd;
                alu_buf_data <= alu_data;
            end
            if (lsu_load) begin
                lsu_buf_rd   <= lsu_rd;
                lsu_buf_data <= lsu_data;
            end
            if (wen_nxt) begin
                rd    <= gnt_rd;
                dataD <= gnt_data;
            end
        end
    end

    // Arbitration, handshakes, next state.
    always_comb begin
        alu_full       = (alu_state == FULL);
        lsu_full       = (lsu_state == FULL);
        starved        = (starve_cnt == CW'(STARVE_MAX));
        gnt_lsu        = lsu_full && !(alu_full && starved);
        gnt_alu        = alu_full && !gnt_lsu;
        grant          = gnt_alu || gnt_lsu;

        // A granted buffer drains this edge, so it can take a new entry now.
        alu_ready      = !alu_full || gnt_alu;
        lsu_ready      = !lsu_full || gnt_lsu;
        alu_load       = alu_valid && alu_ready;
        lsu_load       = lsu_valid && lsu_ready;

        alu_state_nxt  = alu_state;
        if (alu_load)     alu_state_nxt = FULL;
        else if (gnt_alu) alu_state_nxt = EMPTY;

        lsu_state_nxt  = lsu_state;
        if (lsu_load)     lsu_state_nxt = FULL;
        else if (gnt_lsu) lsu_state_nxt = EMPTY;

        gnt_rd         = gnt_lsu ? lsu_buf_rd   : alu_buf_rd;
        gnt_data       = gnt_lsu ? lsu_buf_data : alu_buf_data;
        // x0 entries use their grant slot but never reach the port.
        wen_nxt        = grant && (gnt_rd != '0);

        starve_cnt_nxt = starve_cnt;
        if (!alu_full || gnt_alu)     starve_cnt_nxt = '0;
        else if (gnt_lsu && !starved) starve_cnt_nxt = starve_cnt + CW'(1);
    end

    always_comb begin
        pending = '0;
        if (alu_full) pending[alu_buf_rd] = 1'b1;
        if (lsu_full) pending[lsu_buf_rd] = 1'b1;
        if (wen)      pending[rd]         = 1'b1;
        pending[0] = 1'b0;
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && grant) begin
            if (wen_nxt)
                $display("wb %s x%0d <= 0x%0h(%0d)", gnt_lsu ? "LSU" : "ALU",
                         gnt_rd, gnt_data, $signed(gnt_data));
            else
                $display("wb %s x0 write dropped (0x%0h)", gnt_lsu ? "LSU" : "ALU",
                         gnt_data);
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0;
    logic [4:0]  alu_rd = '0, lsu_rd = '0;
    logic [63:0] alu_data = '0, lsu_data = '0;
    logic        alu_ready, lsu_ready, wen;
    logic [4:0]  rd;
    logic [63:0] dataD;
    logic [31:0] pending;

    wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .STARVE_MAX(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wen(wen), .rd(rd), .dataD(dataD), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [63:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] ld;
        logic        ear;
        logic        elr;
        logic        ewen;
        logic [4:0]  erd;
        logic [63:0] edat;
        logic [31:0] epend;
    } vec_t;

    vec_t tv[64];
    int   nv = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                       input logic ear, input logic elr, input logic ewen,
                       input logic [4:0] erd, input logic [63:0] edat, input logic [31:0] epend);
        tv[nv] = '{av, ard, ad, lv, lrd, ld, ear, elr, ewen, erd, edat, epend};
        nv++;
    endtask

    task automatic idle(input logic ewen, input logic [4:0] erd, input logic [63:0] edat,
                        input logic [31:0] epend);
        add(0, 0, 0, 0, 0, 0, 1, 1, ewen, erd, edat, epend);
    endtask

    task automatic chk(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive_idle();
        alu_valid = 0; lsu_valid = 0;
        alu_rd = 0; alu_data = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    initial begin
        // ---------------- vector table ----------------
        // single ALU write x3 = 0x11 (rows 0..4)
        idle(0, 0, 0, 32'h0);
        add(1, 3, 64'h11, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0);
        idle(0, 0, 0, 32'h8);
        idle(1, 3, 64'h11, 32'h8);
        idle(0, 0, 0, 32'h0);
        // simultaneous: ALU x4=AA, LSU x5=BB -> LSU first
        add(1, 4, 64'hAA, 1, 5, 64'hBB, 1, 1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h30);
        idle(1, 5, 64'hBB, 32'h30);
        idle(1, 4, 64'hAA, 32'h10);
        idle(0, 0, 0, 32'h0);
        // x0 drop, next LSU entry accepted the following cycle
        add(0, 0, 0, 1, 0, 64'hFF, 1, 1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 1, 6, 64'h66, 1, 1, 0, 0, 0, 32'h0);
        idle(0, 0, 0, 32'h40);
        idle(1, 6, 64'h66, 32'h40);
        idle(0, 0, 0, 32'h0);
        // starvation guard: ALU x7 waits, LSU streams x8..x12
        add(1, 7, 64'h77, 1, 8, 64'h80, 1, 1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 1, 9, 64'h90, 0, 1, 0, 0, 0, 32'h180);
        add(0, 0, 0, 1, 10, 64'hA0, 0, 1, 1, 8, 64'h80, 32'h380);
        add(0, 0, 0, 1, 11, 64'hB0, 1, 0, 1, 9, 64'h90, 32'h680);
        add(0, 0, 0, 1, 11, 64'hB0, 1, 1, 1, 7, 64'h77, 32'h480);
        add(0, 0, 0, 1, 12, 64'hC0, 1, 1, 1, 10, 64'hA0, 32'hC00);
        idle(1, 11, 64'hB0, 32'h1800);
        idle(1, 12, 64'hC0, 32'h1000);
        idle(0, 0, 0, 32'h0);
        // back-to-back LSU stream rd=1..8
        for (int k = 0; k < 10; k++) begin
            logic [31:0] p;
            p = '0;
            if (k >= 1 && k <= 8) p[k] = 1'b1;
            if (k >= 2) p[k-1] = 1'b1;
            add(0, 0, 0, (k < 8), (k < 8) ? 5'(k + 1) : 5'd0, (k < 8) ? 64'h100 + 64'(k + 1) : 64'h0,
                1, 1, (k >= 2), (k >= 2) ? 5'(k - 1) : 5'd0,
                (k >= 2) ? 64'h100 + 64'(k - 1) : 64'h0, p);
        end
        idle(0, 0, 0, 32'h0);
        // same rd from both: LSU then ALU, ALU value lands last
        add(1, 13, 64'hD1, 1, 13, 64'hD2, 1, 1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h2000);
        idle(1, 13, 64'hD2, 32'h2000);
        idle(1, 13, 64'hD1, 32'h2000);
        idle(0, 0, 0, 32'h0);

        // ---------------- reset state ----------------
        #2;
        chk("reset_wen", -1, 64'(wen), 64'h0);
        chk("reset_rd", -1, 64'(rd), 64'h0);
        chk("reset_dataD", -1, dataD, 64'h0);
        chk("reset_pending", -1, 64'(pending), 64'h0);
        chk("reset_alu_ready", -1, 64'(alu_ready), 64'h1);
        chk("reset_lsu_ready", -1, 64'(lsu_ready), 64'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // ---------------- table run ----------------
        for (int i = 0; i < nv; i++) begin
            @(posedge clk);
            #1;
            alu_valid = tv[i].av; alu_rd = tv[i].ard; alu_data = tv[i].ad;
            lsu_valid = tv[i].lv; lsu_rd = tv[i].lrd; lsu_data = tv[i].ld;
            @(negedge clk);
            chk("alu_ready", i, 64'(alu_ready), 64'(tv[i].ear));
            chk("lsu_ready", i, 64'(lsu_ready), 64'(tv[i].elr));
            chk("wen", i, 64'(wen), 64'(tv[i].ewen));
            chk("pending", i, 64'(pending), 64'(tv[i].epend));
            if (tv[i].ewen) begin
                chk("rd", i, 64'(rd), 64'(tv[i].erd));
                chk("dataD", i, dataD, tv[i].edat);
            end
        end

        // ---------------- async reset mid-stream ----------------
        @(posedge clk); #1;
        alu_valid = 1; alu_rd = 14; alu_data = 64'hE;
        lsu_valid = 1; lsu_rd = 15; lsu_data = 64'hF;
        @(posedge clk); #1;
        drive_idle();
        @(posedge clk); #1;
        // LSU x15 on the port now, ALU x14 still buffered
        chk("pre_rst_wen", 100, 64'(wen), 64'h1);
        chk("pre_rst_pending", 100, 64'(pending), 64'h0000_C000);
        #2;
        rst = 1;
        #1;
        chk("rst_async_wen", 101, 64'(wen), 64'h0);
        chk("rst_async_pending", 101, 64'(pending), 64'h0);
        chk("rst_async_alu_ready", 101, 64'(alu_ready), 64'h1);
        chk("rst_async_lsu_ready", 101, 64'(lsu_ready), 64'h1);
        @(posedge clk); @(negedge clk);
        rst = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_wen", 102 + c, 64'(wen), 64'h0);
            chk("post_rst_pending", 102 + c, 64'(pending), 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
